srt_div_sched: RTL
==================

# srt_div_sched

Shared-access scheduler for the radix-4 SRT divider datapath (`srt`). Accepts divide requests from up to NREQ requesters and arbitrates round-robin. For each granted request it sequences the divider: clear, start, wait for done, capture the result. It then returns the quotient and remainder with the requester ID, and sits between the requesting units and the single divider instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, ≥ clog2(NREQ)
- TIMEOUT, 16, maximum cycles in WAIT before the op is aborted with error
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  request pending, one bit per requester
- req_n  in  8*NREQ  dividends, requester i at [8i+7:8i]
- req_d  in  6*NREQ  divisors, requester i at [6i+5:6i]
- req_ready  out  NREQ  one-hot grant; the request is accepted on the edge where valid&ready
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_id  out  IDW  index of the requester being answered
- resp_q  out  10  quotient digits
- resp_r  out  8  remainder
- resp_err  out  1  1 = divisor not normalized, or timeout
- div_resetn  out  1  divider reset, active-low
- div_enable  out  1  divider start
- div_n  out  8  registered dividend to divider
- div_d  out  6  registered divisor to divider
- div_done  in  1  divider finished
- div_q  in  10  divider quotient, valid only while div_done=1
- div_r  in  8  divider remainder, valid only while div_done=1

## Operation
- States: IDLE, CLR, START, WAIT, RESP.
- IDLE: if any req_valid, grant the first set bit at or after rr_ptr, scanning upward with wrap. req_ready is combinational in IDLE only; all bits are 0 in every other state.
- On grant: latch N, D and ID; set rr_ptr = winner+1 mod NREQ.
  - D is legal if D[5:4]==2'b01 or D==6'b100000.
  - Legal D → CLR.
  - Illegal D → RESP with err=1, q=0, r=0. The divider is not touched.
- CLR: div_resetn=0 for exactly one cycle → START.
- START: div_enable=1 for exactly one cycle, div_resetn=1 → WAIT. Clear the timeout counter.
- WAIT: div_enable=0.
  - On div_done=1: capture div_q and div_r into resp_q and resp_r, err=0 → RESP.
  - If the counter reaches TIMEOUT first: q=0, r=0, err=1 → RESP.
- RESP: resp_valid=1. resp_* stay stable until resp_ready=1, then → IDLE. No new grant is issued in the same cycle.
- div_resetn=1 in all states except CLR.
- div_n and div_d hold their latched values from grant until the next grant.
- Requesters not granted keep valid high and wait. Requests are never dropped.
- Starvation bound: a continuously valid requester is granted within NREQ grants.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0
  - req_ready=0, resp_valid=0, resp_id=0, resp_q=0, resp_r=0, resp_err=0
  - div_resetn=0, div_enable=0, div_n=0, div_d=0
- Reset held for ≥1 cycle also resets the divider, via div_resetn=0.
- Legal op, grant at cycle G: CLR at G+1, START at G+2, WAIT from G+3. resp_valid rises the cycle after div_done is sampled.
- With the standard divider (done ~6 cycles after enable): resp_valid at about G+9.
- Illegal D: resp_valid at G+1.
- Timeout: resp_valid at G+3+TIMEOUT.
- Back-to-back: the earliest next grant is the cycle after the resp handshake.
- Reset mid-operation: returns to IDLE next cycle. Any in-flight result is discarded. div_resetn=0 during reset.
- div_done asserted outside WAIT is ignored.

## Test plan
- Single request: requester 2, N=8'h64, D=6'b010100, divider stub returns Q=10'h155, R=8'h0C after 6 cycles. Expect req_ready=4'b0100 for one cycle, then div_resetn=0 for one cycle, div_enable pulse, and resp {id=2, q=10'h155, r=8'h0C, err=0}.
- All four valid continuously: grants in order 0,1,2,3,0 with rr_ptr wrap. Each resp_id matches its grant order.
- Illegal D=6'b001111 from requester 1: resp_valid at G+1, err=1, q=0, r=0. div_enable and div_resetn are unchanged.
- Stub never asserts done, TIMEOUT=16: resp err=1 at G+19, then the next request is served normally.
- Backpressure: resp_ready=0 for 5 cycles. resp_* stay stable, no grant during that time, IDLE on the cycle after resp_ready=1.
- Reset asserted in WAIT: next cycle state=IDLE, all outputs at reset values, no resp for the aborted op. The pending request is re-granted after reset releases.

Source files
------------

// File: rtl/srt_div_sched.sv
// srt_div_sched -- round-robin scheduler in front of a single radix-4 SRT divider.
//
// Accepts divide requests from NREQ requesters and grants one at a time. For a
// granted request it clears the divider, pulses its start input and waits for
// done (bounded by TIMEOUT cycles). It then holds the quotient, remainder and
// requester ID on the response port until the consumer takes them.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   req_valid/req_ready        per-requester handshake, ready is one-hot and only in IDLE
//   req_n / req_d              packed dividends (8b each) / divisors (6b each)
//   resp_valid/resp_ready      result handshake
//   resp_id/q/r/err            requester index, quotient, remainder, error flag
//   div_resetn/div_enable      divider clear (active-low) / start pulse
//   div_n / div_d              operands latched at grant, held until next grant
//   div_done/div_q/div_r       divider completion and result (valid with done)
module srt_div_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_n,
    input  logic [6*NREQ-1:0] req_d,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [9:0]        resp_q,
    output logic [7:0]        resp_r,
    output logic              resp_err,
    output logic              div_resetn,
    output logic              div_enable,
    output logic [7:0]        div_n,
    output logic [5:0]        div_d,
    input  logic              div_done,
    input  logic [9:0]        div_q,
    input  logic [7:0]        div_r
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  tmo_cnt;
    logic           tmo_hit;

    logic [NREQ-1:0] cand;
    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [7:0]      win_n;
    logic [5:0]      win_d;
    logic            accept;

    // The divider only produces meaningful digits for a normalized divisor
    // (leading 01) or for exactly 100000.
    function automatic logic d_legal(input logic [5:0] d);
        return (d[5:4] == 2'b01) || (d == 6'b100000);
    endfunction

    // Round-robin pick: first pass looks at indices at/above rr_ptr, second
    // pass wraps to the indices below it.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_n     = '0;
        win_d     = '0;
        cand      = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found && req_valid[j] &&
                    ((pass == 0) == (j >= int'(rr_ptr)))) begin
                    win_found = 1'b1;
                    win_id    = IDW'(j);
                    win_n     = req_n[8*j +: 8];
                    win_d     = req_d[6*j +: 6];
                    cand[j]   = 1'b1;
                end
            end
        end
    end

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = d_legal(win_d) ? CLR : RESP;
            CLR:     state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (div_done || tmo_hit) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; grants are suppressed while reset is asserted so nothing
    // is accepted on a reset edge.
    always_comb begin
        req_ready  = (state == IDLE && !reset) ? cand : '0;
        resp_valid = (state == RESP);
    end

    assign accept = |req_ready;

    // Operand, response and divider-control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            tmo_cnt    <= '0;
            resp_id    <= '0;
            resp_q     <= '0;
            resp_r     <= '0;
            resp_err   <= 1'b0;
            div_resetn <= 1'b0;
            div_enable <= 1'b0;
            div_n      <= '0;
            div_d      <= '0;
        end else begin
            // Divider controls are registered off the next state so they line
            // up exactly with the CLR and START cycles.
            div_resetn <= (state_nxt != CLR);
            div_enable <= (state_nxt == START);
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr  <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
                        resp_id <= win_id;
                        div_n   <= win_n;
                        div_d   <= win_d;
                        if (!d_legal(win_d)) begin
                            resp_q   <= '0;
                            resp_r   <= '0;
                            resp_err <= 1'b1;
                        end
                    end
                end
                START: tmo_cnt <= '0;
                WAIT: begin
                    // done wins over a timeout landing on the same cycle
                    if (div_done) begin
                        resp_q   <= div_q;
                        resp_r   <= div_r;
                        resp_err <= 1'b0;
                    end else if (tmo_hit) begin
                        resp_q   <= '0;
                        resp_r   <= '0;
                        resp_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
